// File: rtl/scamp_io_pkg.sv
// Shared definitions for the SCAMP bus peripherals.
// - tx_state_e : serial transmitter FSM states
// - ST_*       : bit positions inside the 16-bit status word
// - status_word: packs the four status flags into a bus word
package scamp_io_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;
  localparam int unsigned ST_BUSY  = 3;

  function automatic logic [15:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic busy);
    logic [15:0] w;
    w           = '0;
    w[ST_EMPTY] = empty;
    w[ST_FULL]  = full;
    w[ST_OVF]   = ovf;
    w[ST_BUSY]  = busy;
    return w;
  endfunction

endpackage

// File: rtl/serial_out_port_if.sv
// CPU-side signal bundle of the serial output port.
// - addr   : CPU address bus
// - DI, DO : CPU write / read strobes
// - tx     : serial line out (idle high)
// - full   : FIFO full flag
// - busy   : frame in flight or data queued
// The tri-state data bus stays a plain inout port on the peripheral.
interface serial_out_port_if;
  logic [15:0] addr;
  logic        DI;
  logic        DO;
  logic        tx;
  logic        full;
  logic        busy;

  modport master (
    output addr,
    output DI,
    output DO,
    input  tx,
    input  full,
    input  busy
  );

  modport slave (
    input  addr,
    input  DI,
    input  DO,
    output tx,
    output full,
    output busy
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty/full flags.
// - clk, reset_bar : clock, async active-low reset
// - push, din      : write request and data; accepted if not full or popping on the same edge
// - pop, dout      : read request and head-of-queue data (dout valid while !empty)
// - empty, full    : occupancy flags, reflecting state after each edge
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_q;
  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CntW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/serial_out_port.sv
// Memory-mapped serial output port.
// CPU writes to DATA_ADDR queue bus[7:0]; the queue drains as 8N1 serial on tx.
// Reads of STATUS_ADDR return {12'b0, busy, overflow, full, empty} on bus.
// - clk, reset_bar : clock, async active-low reset
// - bus            : CPU data bus, driven only during a status read
// - cpu            : addr, DI/DO strobes, tx, full, busy
module serial_out_port
  import scamp_io_pkg::*;
#(
  parameter logic [15:0] DATA_ADDR    = 16'h0000,
  parameter logic [15:0] STATUS_ADDR  = 16'h0001,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset_bar,
  inout  wire  [15:0]      bus,
  serial_out_port_if.slave cpu
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(8);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(7);

  logic       wr_hit, rd_hit;
  logic       fifo_pop, fifo_empty, fifo_full;
  logic [7:0] fifo_dout;
  logic       ovf_set, baud_end;
  logic [15:0] status;

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;

  assign wr_hit = cpu.DI && (cpu.addr == DATA_ADDR);
  assign rd_hit = cpu.DO && (cpu.addr == STATUS_ADDR);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_bar(reset_bar),
    .push     (wr_hit),
    .pop      (fifo_pop),
    .din      (bus[7:0]),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          tx_d     = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BitLast) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    // A write is dropped only when full and no slot frees on this edge.
    ovf_set    = wr_hit && fifo_full && !fifo_pop;
    overflow_d = overflow_q;
    if (rd_hit)  overflow_d = 1'b0;
    if (ovf_set) overflow_d = 1'b1;
    // Any pop starts a frame, so otherwise the queue is non-empty after the edge
    // exactly when it already was or a write arrives.
    busy_d = (state_d != StIdle) || wr_hit || !fifo_empty;
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  assign status = status_word(fifo_empty, fifo_full, overflow_q, busy_q);
  assign bus    = rd_hit ? status : 16'hzzzz;

  assign cpu.tx   = tx_q;
  assign cpu.full = fifo_full;
  assign cpu.busy = busy_q;

endmodule
